// File: rtl/mesi_bus_ctrl.sv
// mesi_bus_ctrl: round-robin MESI snooping bus arbiter; broadcasts snoops, fetches or
// forwards the line and returns a one-cycle completion to the requester.
module mesi_bus_ctrl #(
  parameter int NUM_CACHE       = 4,
  parameter int LINE_ADDR_WIDTH = 58,
  parameter int LINE_WIDTH      = 512
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2*NUM_CACHE-1:0]          cac2bus_bus_req,
  input  logic [NUM_CACHE-1:0]            cac2bus_write_back,
  input  logic [LINE_ADDR_WIDTH*NUM_CACHE-1:0] cac2bus_addr,
  input  logic [LINE_WIDTH*NUM_CACHE-1:0] cac2bus_data,
  input  logic [2*NUM_CACHE-1:0]          cac2bus_bus_rsp,
  output logic [1:0]                      bus2cac_bus_req,
  output logic [NUM_CACHE-1:0]            bus2cac_snoop_sel,
  output logic [LINE_ADDR_WIDTH-1:0]      bus2cac_addr,
  output logic [LINE_WIDTH-1:0]           bus2cac_data,
  output logic [2*NUM_CACHE-1:0]          bus2cac_bus_rsp,
  output logic                            mem_rd,
  output logic                            mem_wr,
  output logic [LINE_ADDR_WIDTH-1:0]      mem_addr,
  output logic [LINE_WIDTH-1:0]           mem_wdata,
  input  logic [LINE_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_ack,
  output logic                            busy,
  output logic                            err
);
  localparam int IW = $clog2(NUM_CACHE);
  typedef enum logic [2:0] {IDLE, SNOOP, WB, MEM_RD, RESP} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_last, r_req, w_win, w_j, w_flusher;
  logic [1:0] r_type, w_code;
  logic r_evict, r_shared, r_err, w_any, w_shared, w_flush, w_multi;
  logic [LINE_ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_line;
  logic [NUM_CACHE-1:0] w_pend, w_fvec, w_svec, w_req_oh;
  logic [1:0] w_breq [NUM_CACHE];
  logic [1:0] w_rsp [NUM_CACHE];
  logic [LINE_ADDR_WIDTH-1:0] w_addr [NUM_CACHE];
  logic [LINE_WIDTH-1:0] w_data [NUM_CACHE];
  for (genvar g = 0; g < NUM_CACHE; g++) begin : g_port
    assign w_breq[g] = cac2bus_bus_req[2*g +: 2];
    assign w_rsp[g]  = cac2bus_bus_rsp[2*g +: 2];
    assign w_addr[g] = cac2bus_addr[LINE_ADDR_WIDTH*g +: LINE_ADDR_WIDTH];
    assign w_data[g] = cac2bus_data[LINE_WIDTH*g +: LINE_WIDTH];
    assign w_pend[g] = (|w_breq[g]) | cac2bus_write_back[g];
    // the requester's own snoop response never counts
    assign w_fvec[g] = (w_rsp[g] == 2'b10) && (r_req != IW'(g));
    assign w_svec[g] = (w_rsp[g] == 2'b01 || w_rsp[g] == 2'b10) && (r_req != IW'(g));
    assign bus2cac_bus_rsp[2*g +: 2] = (r_state == RESP && r_req == IW'(g)) ? w_code : 2'b00;
  end
  assign w_any     = |w_pend;
  assign w_flush   = |w_fvec;
  assign w_shared  = |w_svec;
  assign w_multi   = |(w_fvec & (w_fvec - NUM_CACHE'(1)));
  assign w_req_oh  = NUM_CACHE'(1) << r_req;
  assign w_code    = (r_evict || r_type == 2'b11) ? 2'b11 : (r_type == 2'b01 && r_shared) ? 2'b10 : 2'b01;
  // scan downwards so the nearest pending cache after r_last wins
  always_comb begin
    w_win = '0;
    w_j   = '0;
    for (int k = NUM_CACHE; k >= 1; k--) begin
      w_j = IW'((int'(r_last) + k) % NUM_CACHE);
      if (w_pend[w_j]) w_win = w_j;
    end
  end
  always_comb begin
    w_flusher = '0;
    for (int k = NUM_CACHE - 1; k >= 0; k--) if (w_fvec[k]) w_flusher = IW'(k);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = (|w_breq[w_win]) ? SNOOP : WB;
      SNOOP:   w_next = w_flush ? WB : (r_type == 2'b11) ? RESP : MEM_RD;
      WB:      if (mem_ack) w_next = RESP;
      MEM_RD:  if (mem_ack) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last   <= IW'(NUM_CACHE - 1);
      r_req    <= '0;
      r_type   <= '0;
      r_evict  <= 1'b0;
      r_shared <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_line   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_req    <= w_win;
          r_last   <= w_win;
          r_type   <= w_breq[w_win];
          r_evict  <= ~|w_breq[w_win];
          r_addr   <= w_addr[w_win];
          r_shared <= 1'b0;
          if (~|w_breq[w_win]) r_line <= w_data[w_win];
        end
        SNOOP: begin
          r_shared <= w_shared;
          r_err    <= r_err | w_multi;
          if (w_flush) r_line <= w_data[w_flusher];
        end
        MEM_RD: if (mem_ack) r_line <= mem_rdata;
        default: ;
      endcase
    end
  end
  assign bus2cac_bus_req   = (r_state == SNOOP) ? r_type : 2'b00;
  assign bus2cac_snoop_sel = (r_state == SNOOP) ? ~w_req_oh : '0;
  assign bus2cac_addr      = r_addr;
  assign bus2cac_data      = r_line;
  assign mem_addr          = r_addr;
  assign mem_wdata         = r_line;
  assign mem_rd            = r_state == MEM_RD;
  assign mem_wr            = r_state == WB;
  assign busy              = r_state != IDLE;
  assign err               = r_err;
endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// tb_mesi_bus_ctrl: scenario tasks with a completion scoreboard and a latency-programmable memory model.
module tb_mesi_bus_ctrl;
  localparam int N = 4, AW = 58, LW = 512;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2*N-1:0]  bus_req, rsp, b_rsp;
  logic [N-1:0]    wb, sel;
  logic [AW*N-1:0] addr;
  logic [LW*N-1:0] cdata;
  logic [1:0]      b_req;
  logic [AW-1:0]   b_addr, mem_addr;
  logic [LW-1:0]   b_data, mem_wdata, mem_rdata;
  logic            mem_rd, mem_wr, mem_ack, busy, err;
  mesi_bus_ctrl #(.NUM_CACHE(N), .LINE_ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cac2bus_bus_req(bus_req), .cac2bus_write_back(wb),
    .cac2bus_addr(addr), .cac2bus_data(cdata), .cac2bus_bus_rsp(rsp),
    .bus2cac_bus_req(b_req), .bus2cac_snoop_sel(sel), .bus2cac_addr(b_addr),
    .bus2cac_data(b_data), .bus2cac_bus_rsp(b_rsp), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err));
  typedef struct { int idx; logic [1:0] code; bit chk; logic [LW-1:0] data; } exp_t;
  exp_t sb[$];
  int rr_cyc[$];
  int n_vec = 0, n_err = 0, cyc = 0, mem_lat = 1;
  int done_cnt = 0, done_cyc = 0, rd_cycles = 0, wr_cycles = 0, snoop_cnt = 0;
  logic [N-1:0]  sel_seen = '0;
  logic [1:0]    sreq_seen = '0;
  logic [LW-1:0] wdata_seen = '0;
  logic [AW-1:0] maddr_seen = '0;
  always @(posedge clk) cyc <= cyc + 1;
  // memory acks in strobe cycle mem_lat
  initial begin
    int mcnt;
    mcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_rd || mem_wr) begin
        if (mcnt >= mem_lat - 1) begin mem_ack = 1'b1; mcnt = 0; end
        else mcnt++;
      end else mcnt = 0;
    end
  end
  initial begin
    int hit, nz;
    logic [1:0] code;
    exp_t e;
    forever begin
      @(negedge clk);
      if (sel !== '0) begin sel_seen = sel; sreq_seen = b_req; snoop_cnt++; end
      if (mem_rd) begin rd_cycles++; maddr_seen = mem_addr; end
      if (mem_wr) begin wr_cycles++; wdata_seen = mem_wdata; maddr_seen = mem_addr; end
      if (b_rsp !== '0) begin
        nz = 0; hit = -1; code = 2'b00;
        for (int i = 0; i < N; i++) if (b_rsp[2*i +: 2] !== 2'b00) begin nz++; hit = i; code = b_rsp[2*i +: 2]; end
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL completion: unexpected pulse cache %0d code %b, none required", hit, code);
        end else begin
          e = sb.pop_front();
          if (nz != 1 || hit != e.idx || code !== e.code || (e.chk && b_data !== e.data)) begin
            n_err++;
            $display("FAIL completion: got cache %0d code %b data %h, required cache %0d code %b data %h",
                     hit, code, b_data, e.idx, e.code, e.data);
          end
        end
        done_cnt++;
        done_cyc = cyc;
        rr_cyc.push_back(cyc);
      end
    end
  end
  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end
  task automatic set_cache(input int i, input logic [1:0] r, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    bus_req[2*i +: 2] = r; wb[i] = w; addr[AW*i +: AW] = a; cdata[LW*i +: LW] = d;
  endtask
  task automatic clear_all();
    bus_req = '0; wb = '0; rsp = '0;
  endtask
  task automatic wait_done(input int tgt, input int budget);
    int k;
    k = 0;
    while (done_cnt < tgt && k < budget) begin @(negedge clk); k++; end
  endtask
  task automatic test_reset();
    rst_n = 1'b0; clear_all(); addr = '0; cdata = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, err, mem_rd, mem_wr} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b required 0000", {busy, err, mem_rd, mem_wr}); end
    n_vec++;
    if ({b_rsp, sel, b_req} !== '0) begin n_err++; $display("FAIL reset_bus: got %h required 0", {b_rsp, sel, b_req}); end
    n_vec++;
    if (mem_addr !== '0 || b_addr !== '0 || mem_wdata !== '0 || b_data !== '0) begin
      n_err++; $display("FAIL reset_data: got addr %h nonzero_data %b required 0", mem_addr, |{mem_wdata, b_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_excl_read();
    int base, rc, rd0;
    @(negedge clk); clear_all();
    mem_lat = 2; mem_rdata = {64{8'hAA}}; base = done_cnt; rd0 = rd_cycles;
    set_cache(0, 2'b01, 1'b0, 58'h12, '0);
    rc = cyc;
    sb.push_back('{0, 2'b01, 1'b1, {64{8'hAA}}});
    wait_done(base + 1, 40); clear_all();
    n_vec++; if (done_cnt != base + 1) begin n_err++; $display("FAIL excl_done: got %0d completions required %0d", done_cnt - base, 1); end
    n_vec++; if (sel_seen !== 4'b1110) begin n_err++; $display("FAIL excl_sel: got %b required 1110", sel_seen); end
    n_vec++; if (sreq_seen !== 2'b01) begin n_err++; $display("FAIL excl_snoop_req: got %b required 01", sreq_seen); end
    n_vec++; if (rd_cycles - rd0 != 2) begin n_err++; $display("FAIL excl_mem_rd_len: got %0d required 2", rd_cycles - rd0); end
    n_vec++; if (maddr_seen !== 58'h12) begin n_err++; $display("FAIL excl_mem_addr: got %h required 12", maddr_seen); end
    n_vec++; if (done_cyc - rc != 4) begin n_err++; $display("FAIL excl_latency: got %0d required 4", done_cyc - rc); end
  endtask
  task automatic test_shared_read();
    int base, rc, rd0, wr0;
    @(negedge clk); clear_all();
    mem_lat = 1; mem_rdata = {64{8'h33}}; base = done_cnt; rd0 = rd_cycles; wr0 = wr_cycles;
    set_cache(1, 2'b01, 1'b0, 58'h40, {64{8'hEE}});
    rsp[5:4] = 2'b01;
    rsp[3:2] = 2'b10;
    rc = cyc;
    sb.push_back('{1, 2'b10, 1'b1, {64{8'h33}}});
    wait_done(base + 1, 40); clear_all();
    n_vec++; if (done_cnt != base + 1) begin n_err++; $display("FAIL shared_done: got %0d completions required 1", done_cnt - base); end
    n_vec++; if (rd_cycles - rd0 != 1 || wr_cycles != wr0) begin n_err++; $display("FAIL shared_mem: got rd %0d wr %0d required rd 1 wr 0", rd_cycles - rd0, wr_cycles - wr0); end
    n_vec++; if (sel_seen !== 4'b1101) begin n_err++; $display("FAIL shared_sel: got %b required 1101", sel_seen); end
    n_vec++; if (done_cyc - rc != 3) begin n_err++; $display("FAIL shared_latency: got %0d required 3", done_cyc - rc); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL shared_err: got %b required 0", err); end
  endtask
  task automatic test_flush();
    int base, rc, rd0, wr0;
    @(negedge clk); clear_all();
    mem_lat = 1; mem_rdata = {64{8'hAA}}; base = done_cnt; rd0 = rd_cycles; wr0 = wr_cycles;
    set_cache(0, 2'b00, 1'b0, 58'h0, {64{8'h55}});
    set_cache(3, 2'b10, 1'b0, 58'h07, '0);
    rsp[1:0] = 2'b10;
    rc = cyc;
    sb.push_back('{3, 2'b01, 1'b1, {64{8'h55}}});
    wait_done(base + 1, 40); clear_all();
    n_vec++; if (done_cnt != base + 1) begin n_err++; $display("FAIL flush_done: got %0d completions required 1", done_cnt - base); end
    n_vec++; if (wr_cycles - wr0 != 1 || rd_cycles != rd0) begin n_err++; $display("FAIL flush_mem: got wr %0d rd %0d required wr 1 rd 0", wr_cycles - wr0, rd_cycles - rd0); end
    n_vec++; if (wdata_seen !== {64{8'h55}}) begin n_err++; $display("FAIL flush_wdata: got %h required 55..55", wdata_seen); end
    n_vec++; if (sreq_seen !== 2'b10 || sel_seen !== 4'b0111) begin n_err++; $display("FAIL flush_snoop: got req %b sel %b required 10 0111", sreq_seen, sel_seen); end
    n_vec++; if (maddr_seen !== 58'h07) begin n_err++; $display("FAIL flush_addr: got %h required 7", maddr_seen); end
    n_vec++; if (done_cyc - rc != 3) begin n_err++; $display("FAIL flush_latency: got %0d required 3", done_cyc - rc); end
  endtask
  task automatic test_evict();
    int base, rc, wr0, sn0;
    @(negedge clk); clear_all();
    mem_lat = 1; base = done_cnt; wr0 = wr_cycles; sn0 = snoop_cnt;
    set_cache(2, 2'b00, 1'b1, 58'h99, {64{8'h0F}});
    rc = cyc;
    sb.push_back('{2, 2'b11, 1'b0, '0});
    wait_done(base + 1, 40); clear_all();
    n_vec++; if (done_cnt != base + 1) begin n_err++; $display("FAIL evict_done: got %0d completions required 1", done_cnt - base); end
    n_vec++; if (wr_cycles - wr0 != 1 || wdata_seen !== {64{8'h0F}}) begin n_err++; $display("FAIL evict_wr: got %0d cycles data %h required 1 cycle 0f..0f", wr_cycles - wr0, wdata_seen); end
    n_vec++; if (snoop_cnt != sn0) begin n_err++; $display("FAIL evict_snoop: got %0d snoop cycles required 0", snoop_cnt - sn0); end
    n_vec++; if (maddr_seen !== 58'h99) begin n_err++; $display("FAIL evict_addr: got %h required 99", maddr_seen); end
    n_vec++; if (done_cyc - rc != 2) begin n_err++; $display("FAIL evict_latency: got %0d required 2", done_cyc - rc); end
  endtask
  task automatic test_double_flush();
    int base, rd0;
    @(negedge clk); clear_all();
    mem_lat = 1; base = done_cnt; rd0 = rd_cycles;
    set_cache(1, 2'b00, 1'b0, 58'h0, {64{8'h11}});
    set_cache(2, 2'b00, 1'b0, 58'h0, {64{8'h22}});
    set_cache(3, 2'b01, 1'b0, 58'h21, '0);
    rsp[3:2] = 2'b10; rsp[5:4] = 2'b10;
    sb.push_back('{3, 2'b10, 1'b1, {64{8'h11}}});
    wait_done(base + 1, 40); clear_all();
    n_vec++; if (done_cnt != base + 1) begin n_err++; $display("FAIL dflush_done: got %0d completions required 1", done_cnt - base); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL dflush_err: got %b required 1", err); end
    n_vec++; if (wdata_seen !== {64{8'h11}} || rd_cycles != rd0) begin n_err++; $display("FAIL dflush_wdata: got %h rd %0d required 11..11 rd 0", wdata_seen, rd_cycles - rd0); end
  endtask
  task automatic test_req_over_wb();
    int base, rc, wr0;
    @(negedge clk); clear_all();
    base = done_cnt; wr0 = wr_cycles;
    set_cache(1, 2'b11, 1'b1, 58'h05, {64{8'h77}});
    rc = cyc;
    sb.push_back('{1, 2'b11, 1'b0, '0});
    wait_done(base + 1, 40); clear_all();
    n_vec++; if (done_cnt != base + 1) begin n_err++; $display("FAIL upgr_done: got %0d completions required 1", done_cnt - base); end
    n_vec++; if (wr_cycles != wr0 || sel_seen !== 4'b1101 || sreq_seen !== 2'b11) begin n_err++; $display("FAIL upgr_snoop: got wr %0d sel %b req %b required 0 1101 11", wr_cycles - wr0, sel_seen, sreq_seen); end
    n_vec++; if (done_cyc - rc != 2) begin n_err++; $display("FAIL upgr_latency: got %0d required 2", done_cyc - rc); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b required 1", err); end
  endtask
  task automatic test_reset_mid();
    int base, k;
    @(negedge clk); clear_all();
    mem_lat = 40; base = done_cnt;
    set_cache(0, 2'b01, 1'b0, 58'h03, '0);
    k = 0;
    while (!mem_rd && k < 20) begin @(negedge clk); k++; end
    n_vec++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL rstmid_mem_rd_start: got %b required 1", mem_rd); end
    rst_n = 1'b0; clear_all();
    @(negedge clk);
    n_vec++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_drop: got mem_rd %b busy %b required 0 0", mem_rd, busy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rstmid_err: got %b required 0", err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mem_lat = 1;
    repeat (5) @(negedge clk);
    n_vec++; if (done_cnt != base || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_no_completion: got %0d pulses busy %b required 0 0", done_cnt - base, busy); end
  endtask
  task automatic test_round_robin();
    int base, rc;
    @(negedge clk); clear_all();
    base = done_cnt; rr_cyc.delete();
    for (int i = 0; i < N; i++) set_cache(i, 2'b11, 1'b0, AW'(8'h60 + i), '0);
    rc = cyc;
    for (int i = 0; i < 5; i++) sb.push_back('{i % N, 2'b11, 1'b0, '0});
    wait_done(base + 5, 60); clear_all();
    n_vec++; if (done_cnt != base + 5 || rr_cyc.size() < 5) begin n_err++; $display("FAIL rr_done: got %0d completions required 5", done_cnt - base); end
    else begin
      n_vec++; if (rr_cyc[0] - rc != 2) begin n_err++; $display("FAIL rr_first_latency: got %0d required 2", rr_cyc[0] - rc); end
      for (int i = 1; i < 5; i++) begin
        n_vec++;
        if (rr_cyc[i] - rr_cyc[i-1] != 3) begin n_err++; $display("FAIL rr_interval_%0d: got %0d required 3", i, rr_cyc[i] - rr_cyc[i-1]); end
      end
    end
    repeat (6) @(negedge clk);
    n_vec++; if (sb.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL rr_drain: got %0d outstanding busy %b required 0 0", sb.size(), busy); end
  endtask
  initial begin
    test_reset();
    test_excl_read();
    test_shared_read();
    test_flush();
    test_evict();
    test_double_flush();
    test_req_over_wb();
    test_reset_mid();
    test_round_robin();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
